// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory stage: funct3 encodings, FSM states
// and the access-size decode used by both the aligner and the stage.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;

  // Unsigned variants only exist for loads, so a store with funct3[2]=1 is illegal.
  function automatic size_e size_decode(input logic [2:0] funct3, input logic we);
    size_e sz;
    sz = SZ_BAD;
    case (funct3)
      F3_B:    sz = SZ_B;
      F3_H:    sz = SZ_H;
      F3_W:    sz = SZ_W;
      F3_BU:   sz = we ? SZ_BAD : SZ_B;
      F3_HU:   sz = we ? SZ_BAD : SZ_H;
      default: sz = SZ_BAD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dmem_ldst_align.sv
// Combinational lane logic: store byte-enables and shifted data, load lane
// select with sign/zero extension, and misaligned/illegal request detection.
module ldst_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic              we_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN/8-1:0] be_o,
  output logic [XLEN-1:0]   wdata_sh_o,
  output logic              misaligned_o,
  output logic              illegal_o,
  input  logic [2:0]        ld_funct3_i,
  input  logic [1:0]        ld_off_i,
  input  logic [XLEN-1:0]   ld_word_i,
  output logic [XLEN-1:0]   ld_data_o
);

  localparam int NB = XLEN / 8;

  size_e           sz;
  size_e           ld_sz;
  logic [XLEN-1:0] ld_sh;

  assign sz    = size_decode(funct3_i, we_i);
  assign ld_sz = size_decode(ld_funct3_i, 1'b0);

  always_comb begin
    illegal_o    = (sz == SZ_BAD);
    misaligned_o = ((sz == SZ_H) && addr_lo_i[0]) || ((sz == SZ_W) && (addr_lo_i != 2'b00));
    be_o         = '0;
    case (sz)
      SZ_B:    be_o = NB'(1) << addr_lo_i;
      SZ_H:    be_o = NB'(3) << addr_lo_i;
      SZ_W:    be_o = '1;
      default: be_o = '0;
    endcase
    wdata_sh_o = wdata_i << {addr_lo_i, 3'b000};
  end

  // funct3[2] distinguishes the zero-extending lbu/lhu from lb/lh.
  always_comb begin
    ld_sh     = ld_word_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_sh;
    case (ld_sz)
      SZ_B: ld_data_o = ld_funct3_i[2] ? {{(XLEN-8){1'b0}}, ld_sh[7:0]}
                                       : {{(XLEN-8){ld_sh[7]}}, ld_sh[7:0]};
      SZ_H: ld_data_o = ld_funct3_i[2] ? {{(XLEN-16){1'b0}}, ld_sh[15:0]}
                                       : {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      default: ld_data_o = ld_sh;
    endcase
  end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: byte-lane RAM, load-latency FSM and fault pulse.
// Optional statistics counters are built when DMEM_STATS_EN is defined.
module dmem_stage
  import dmem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            fault
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]     load_cnt,
  output logic [31:0]     store_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              fault_q, fault_d;
  logic [2:0]        ld_funct3_q;
  logic [1:0]        ld_off_q;

  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   word_rd;
  logic [XLEN-1:0]   ld_data;
  logic              misaligned, illegal;
  logic              accept, bad, acc_load, acc_store;
  logic [AW-1:0]     idx;
  logic              unused_addr_bits;

  assign idx              = req_addr[2+AW-1:2];
  assign unused_addr_bits = ^req_addr[XLEN-1:2+AW];
  assign req_ready        = (state_q == IDLE);
  assign accept           = req_valid & req_ready;
  assign bad              = misaligned | illegal;
  assign acc_load         = accept & ~req_we & ~bad;
  assign acc_store        = accept &  req_we & ~bad;

  ldst_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (req_funct3),
    .we_i         (req_we),
    .addr_lo_i    (req_addr[1:0]),
    .wdata_i      (req_wdata),
    .be_o         (be),
    .wdata_sh_o   (wdata_sh),
    .misaligned_o (misaligned),
    .illegal_o    (illegal),
    .ld_funct3_i  (ld_funct3_q),
    .ld_off_i     (ld_off_q),
    .ld_word_i    (word_rd),
    .ld_data_o    (ld_data)
  );

  // One RAM per byte lane; the read is registered at acceptance so the load
  // returns pre-request contents regardless of latency.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (acc_store && be[gi]) lane_mem[idx] <= wdata_sh[gi*8 +: 8];
      if (acc_load)            rd_q          <= lane_mem[idx];
    end

    assign word_rd[gi*8 +: 8] = rd_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    fault_d      = accept & bad;
    case (state_q)
      IDLE: begin
        if (acc_load) begin
          state_d = BUSY;
          cnt_d   = 2'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 2'd0) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_data;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      fault_q      <= 1'b0;
      ld_funct3_q  <= '0;
      ld_off_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      fault_q      <= fault_d;
      if (acc_load) begin
        ld_funct3_q <= req_funct3;
        ld_off_q    <= req_addr[1:0];
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign fault      = fault_q;

`ifdef DMEM_STATS_EN
  logic [31:0] load_cnt_q, store_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (acc_load)               load_cnt_q  <= load_cnt_q + 32'd1;
      if (acc_store)              store_cnt_q <= store_cnt_q + 32'd1;
      if (req_valid & ~req_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_stage.sv
// Bench for dmem_stage: three instances (LATENCY 1, 3, 4) checked against a
// byte-addressed reference memory with directed and random requests.
module tb_dmem_stage;

  localparam int NDUT = 3;
  localparam int MEMB = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid  [NDUT];
  logic        req_we     [NDUT];
  logic [2:0]  req_funct3 [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        req_ready  [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        fault      [NDUT];
`ifdef DMEM_STATS_EN
  logic [31:0] load_cnt   [NDUT];
  logic [31:0] store_cnt  [NDUT];
  logic [31:0] stall_cnt  [NDUT];
  int          ld_m [NDUT];
  int          st_m [NDUT];
  int          stall_m [NDUT];
`endif

  logic [7:0] mem_m [NDUT][MEMB];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    dmem_stage #(.XLEN(32), .DEPTH(64), .LATENCY(gi == 0 ? 1 : (gi == 1 ? 3 : 4))) u_dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[gi]),
      .req_we     (req_we[gi]),
      .req_funct3 (req_funct3[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
      .req_ready  (req_ready[gi]),
      .resp_valid (resp_valid[gi]),
      .resp_rdata (resp_rdata[gi]),
      .fault      (fault[gi])
`ifdef DMEM_STATS_EN
      ,
      .load_cnt   (load_cnt[gi]),
      .store_cnt  (store_cnt[gi]),
      .stall_cnt  (stall_cnt[gi])
`endif
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic bit legal_f3(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic [31:0] exp_load(input int k, input logic [2:0] f3, input int a);
    int v;
    case (f3)
      3'd0: begin v = mem_m[k][a]; return (v >= 128) ? 32'(v - 256) : 32'(v); end
      3'd4: return 32'(mem_m[k][a]);
      3'd1: begin v = mem_m[k][a] + 256 * mem_m[k][a+1]; return (v >= 32768) ? 32'(v - 65536) : 32'(v); end
      3'd5: return 32'(mem_m[k][a] + 256 * mem_m[k][a+1]);
      default: return {mem_m[k][a+3], mem_m[k][a+2], mem_m[k][a+1], mem_m[k][a]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    req_valid[k]  = 1'b0;
    req_we[k]     = 1'b0;
    req_funct3[k] = 3'd0;
    req_addr[k]   = 32'd0;
    req_wdata[k]  = 32'd0;
  endtask

  // Issue one request at a negedge and check everything up to its completion.
  task automatic do_req(input int k, input bit we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    int a;
    int n;
    int sz;
    bit bad;
    logic [31:0] exp;
    a   = int'(addr % MEMB);
    sz  = size_of(f3);
    bad = !legal_f3(we, f3) || (sz == 2 && (a % 2) != 0) || (sz == 4 && (a % 4) != 0);
    req_valid[k] = 1'b1; req_we[k] = we; req_funct3[k] = f3;
    req_addr[k] = addr; req_wdata[k] = wd;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("ready_at_issue", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    exp = 32'd0;
    if (!bad && we) begin
      for (int i = 0; i < sz; i++) mem_m[k][a+i] = wd[8*i +: 8];
    end
    if (!bad && !we) exp = exp_load(k, f3, a);
`ifdef DMEM_STATS_EN
    if (!bad && we)  st_m[k]++;
    if (!bad && !we) ld_m[k]++;
`endif
    @(negedge clk);
    idle_inputs(k);
    if (bad) begin
      chk("fault_pulse", 32'(fault[k]), 32'd1);
      chk("fault_no_resp", 32'(resp_valid[k]), 32'd0);
      chk("fault_ready", 32'(req_ready[k]), 32'd1);
      @(negedge clk);
      chk("fault_one_cycle", 32'(fault[k]), 32'd0);
      chk("fault_no_resp2", 32'(resp_valid[k]), 32'd0);
    end else if (we) begin
      chk("store_no_fault", 32'(fault[k]), 32'd0);
      chk("store_no_resp", 32'(resp_valid[k]), 32'd0);
      chk("store_ready", 32'(req_ready[k]), 32'd1);
    end else begin
      for (int i = 0; i < lat_of(k); i++) begin
        chk("busy_ready_low", 32'(req_ready[k]), 32'd0);
        chk("busy_no_resp", 32'(resp_valid[k]), 32'd0);
        @(negedge clk);
      end
      chk("resp_valid", 32'(resp_valid[k]), 32'd1);
      chk("resp_rdata", resp_rdata[k], exp);
      chk("resp_ready", 32'(req_ready[k]), 32'd1);
      chk("resp_no_fault", 32'(fault[k]), 32'd0);
      @(negedge clk);
      chk("resp_pulse", 32'(resp_valid[k]), 32'd0);
      chk("rdata_hold", resp_rdata[k], exp);
    end
  endtask

  // Two lw with req_valid held; the second is accepted on the response cycle.
  task automatic b2b(input int k, input logic [31:0] a1, input logic [31:0] a2);
    logic [31:0] e1, e2;
    req_valid[k] = 1'b1; req_we[k] = 1'b0; req_funct3[k] = 3'd2; req_addr[k] = a1;
    chk("b2b_ready0", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    e1 = exp_load(k, 3'd2, int'(a1 % MEMB));
    e2 = exp_load(k, 3'd2, int'(a2 % MEMB));
    @(negedge clk);
    req_addr[k] = a2;
    for (int i = 0; i < lat_of(k); i++) begin
      chk("b2b_stall1", 32'(req_ready[k]), 32'd0);
      chk("b2b_noresp1", 32'(resp_valid[k]), 32'd0);
      @(negedge clk);
    end
    chk("b2b_resp1", 32'(resp_valid[k]), 32'd1);
    chk("b2b_data1", resp_rdata[k], e1);
    chk("b2b_ready_resp", 32'(req_ready[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    idle_inputs(k);
    for (int i = 0; i < lat_of(k); i++) begin
      chk("b2b_stall2", 32'(req_ready[k]), 32'd0);
      chk("b2b_noresp2", 32'(resp_valid[k]), 32'd0);
      @(negedge clk);
    end
    chk("b2b_resp2", 32'(resp_valid[k]), 32'd1);
    chk("b2b_data2", resp_rdata[k], e2);
`ifdef DMEM_STATS_EN
    ld_m[k] += 2;
    stall_m[k] += lat_of(k);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] addr;
    logic [2:0]  f3;
    bit          we;
    for (int k = 0; k < NDUT; k++) begin
      idle_inputs(k);
`ifdef DMEM_STATS_EN
      ld_m[k] = 0; st_m[k] = 0; stall_m[k] = 0;
`endif
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", 32'(req_ready[k]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
      chk("rst_rdata", resp_rdata[k], 32'd0);
      chk("rst_fault", 32'(fault[k]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < NDUT; k++)
      for (int w = 0; w < MEMB / 4; w++) do_req(k, 1'b1, 3'd2, 32'(w * 4), $urandom);

    do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("tp_lw_deadbeef", resp_rdata[0], 32'hDEADBEEF);
    do_req(0, 1'b1, 3'd0, 32'h13, 32'h00000080);
    do_req(0, 1'b0, 3'd0, 32'h13, 32'h0);
    chk("tp_lb", resp_rdata[0], 32'hFFFFFF80);
    do_req(0, 1'b0, 3'd4, 32'h13, 32'h0);
    chk("tp_lbu", resp_rdata[0], 32'h00000080);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("tp_lw_merged", resp_rdata[0], 32'h80ADBEEF);
    do_req(0, 1'b0, 3'd1, 32'h11, 32'h0);
    do_req(0, 1'b1, 3'd2, 32'h12, 32'h55555555);
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    chk("tp_unchanged", resp_rdata[0], 32'h80ADBEEF);
    do_req(0, 1'b1, 3'd3, 32'h10, 32'h11111111);
    do_req(0, 1'b0, 3'd6, 32'h10, 32'h0);
    do_req(0, 1'b1, 3'd2, 32'h100, 32'h12345678);
    do_req(0, 1'b0, 3'd2, 32'h000, 32'h0);
    chk("tp_wrap", resp_rdata[0], 32'h12345678);
    do_req(0, 1'b0, 3'd5, 32'h102, 32'h0);
    do_req(0, 1'b0, 3'd1, 32'h002, 32'h0);

    for (int k = 0; k < NDUT; k++) begin
      for (int n = 0; n < 60; n++) begin
        we   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = 32'($urandom);
        if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
        do_req(k, we, f3, addr, $urandom);
      end
    end

    b2b(2, 32'h20, 32'h24);
    b2b(0, 32'h30, 32'h34);
`ifdef DMEM_STATS_EN
    for (int k = 0; k < NDUT; k++) begin
      chk("stat_load", load_cnt[k], 32'(ld_m[k]));
      chk("stat_store", store_cnt[k], 32'(st_m[k]));
      chk("stat_stall", stall_cnt[k], 32'(stall_m[k]));
    end
`endif

    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2; req_addr[1] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    idle_inputs(1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("midrst_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_rdata", resp_rdata[1], 32'd0);
    chk("midrst_fault", 32'(fault[1]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_resp", 32'(resp_valid[1]), 32'd0);
      chk("midrst_ready_hi", 32'(req_ready[1]), 32'd1);
    end
`ifdef DMEM_STATS_EN
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_load_cnt", load_cnt[k], 32'd0);
      chk("rst_store_cnt", store_cnt[k], 32'd0);
      chk("rst_stall_cnt", stall_cnt[k], 32'd0);
    end
`endif
    do_req(1, 1'b0, 3'd2, 32'h10, 32'h0);
    do_req(1, 1'b0, 3'd0, 32'h13, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
